// File: rtl/dsp_w_dispatcher_pkg.sv
// dsp_w_dispatcher_pkg: slice-index and slave-ID range helpers shared by the AW/W/B dispatchers
package dsp_w_dispatcher_pkg;
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction
  function automatic logic id_oor(input int unsigned id, input int unsigned amt);
    return id >= amt;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered circular buffer with occupancy count; push while full only lands when a pop frees the slot
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/dsp_w_dispatcher.sv
// dsp_w_dispatcher: steers W beats to the slave at the head of the outstanding-AW ID FIFO
module dsp_w_dispatcher
  import dsp_w_dispatcher_pkg::*;
#(
  parameter int SLV_AMT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int SLV_ID_W   = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int OSTD_DEPTH = 4
) (
  input  logic                             ACLK_i,
  input  logic                             ARESETn_i,
  input  logic                             aw_push_i,
  input  logic [SLV_ID_W-1:0]              aw_slv_id_i,
  output logic                             aw_full_o,
  input  logic [DATA_WIDTH-1:0]            m_WDATA_i,
  input  logic [STRB_WIDTH-1:0]            m_WSTRB_i,
  input  logic                             m_WLAST_i,
  input  logic                             m_WVALID_i,
  output logic                             m_WREADY_o,
  output logic [DATA_WIDTH*SLV_AMT-1:0]    sa_WDATA_o,
  output logic [STRB_WIDTH*SLV_AMT-1:0]    sa_WSTRB_o,
  output logic [SLV_AMT-1:0]               sa_WLAST_o,
  output logic [SLV_AMT-1:0]               sa_WVALID_o,
  input  logic [SLV_AMT-1:0]               sa_WREADY_i,
  output logic [$clog2(OSTD_DEPTH+1)-1:0]  ostd_cnt_o,
  output logic                             wr_err_o
);
  logic [SLV_ID_W-1:0] w_head;
  logic                w_empty, w_oor, w_sel_rdy, w_pop;
  logic                r_wr_err;
  sync_fifo #(.WIDTH(SLV_ID_W), .DEPTH(OSTD_DEPTH)) u_fifo (
    .i_clk   (ACLK_i),
    .i_rst_n (ARESETn_i),
    .i_push  (aw_push_i),
    .i_pop   (w_pop),
    .i_data  (aw_slv_id_i),
    .o_data  (w_head),
    .o_full  (aw_full_o),
    .o_empty (w_empty),
    .o_count (ostd_cnt_o)
  );
  assign w_oor = id_oor(32'(w_head), SLV_AMT);
  always_comb begin
    sa_WDATA_o  = '0;
    sa_WSTRB_o  = '0;
    sa_WVALID_o = '0;
    w_sel_rdy   = 1'b0;
    for (int i = 0; i < SLV_AMT; i++) begin
      sa_WDATA_o[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = m_WDATA_i;
      sa_WSTRB_o[slice_lo(i, STRB_WIDTH) +: STRB_WIDTH] = m_WSTRB_i;
      if (!w_empty && w_head == SLV_ID_W'(i)) begin
        sa_WVALID_o[i] = m_WVALID_i;
        w_sel_rdy      = sa_WREADY_i[i];
      end
    end
  end
  assign sa_WLAST_o = {SLV_AMT{m_WLAST_i}};
  // out-of-range heads are drained locally so the master never deadlocks
  assign m_WREADY_o = ~w_empty & (w_oor | w_sel_rdy);
  assign w_pop      = m_WVALID_i & m_WREADY_o & m_WLAST_i;
  assign wr_err_o   = r_wr_err;
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) r_wr_err <= 1'b0;
    else            r_wr_err <= w_pop & w_oor;
  end
endmodule

// File: tb/tb_dsp_w_dispatcher.sv
// tb_dsp_w_dispatcher: table-driven W dispatcher checks plus reset and out-of-range sequences
module tb_dsp_w_dispatcher;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aw_push = 1'b0;
  logic [1:0]   aw_id = '0;
  logic         aw_full;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, wready;
  logic [127:0] sa_wdata;
  logic [15:0]  sa_wstrb;
  logic [3:0]   sa_wlast, sa_wvalid, sa_wready = '0;
  logic [2:0]   cnt;
  logic         wr_err;
  logic         d3_push = 1'b0;
  logic [1:0]   d3_id = '0;
  logic         d3_full, d3_wlast = 1'b0, d3_wvalid = 1'b0, d3_wready;
  logic [95:0]  d3_wdata;
  logic [11:0]  d3_wstrb;
  logic [2:0]   d3_sa_wlast, d3_sa_wvalid, d3_sa_wready = '0;
  logic [2:0]   d3_cnt;
  logic         d3_err;
  int           n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  dsp_w_dispatcher u_dut (
    .ACLK_i(clk), .ARESETn_i(rst_n), .aw_push_i(aw_push), .aw_slv_id_i(aw_id),
    .aw_full_o(aw_full), .m_WDATA_i(wdata), .m_WSTRB_i(wstrb), .m_WLAST_i(wlast),
    .m_WVALID_i(wvalid), .m_WREADY_o(wready), .sa_WDATA_o(sa_wdata), .sa_WSTRB_o(sa_wstrb),
    .sa_WLAST_o(sa_wlast), .sa_WVALID_o(sa_wvalid), .sa_WREADY_i(sa_wready),
    .ostd_cnt_o(cnt), .wr_err_o(wr_err)
  );

  dsp_w_dispatcher #(.SLV_AMT(3)) u_dut3 (
    .ACLK_i(clk), .ARESETn_i(rst_n), .aw_push_i(d3_push), .aw_slv_id_i(d3_id),
    .aw_full_o(d3_full), .m_WDATA_i(32'h0BAD_F00D), .m_WSTRB_i(4'hF), .m_WLAST_i(d3_wlast),
    .m_WVALID_i(d3_wvalid), .m_WREADY_o(d3_wready), .sa_WDATA_o(d3_wdata), .sa_WSTRB_o(d3_wstrb),
    .sa_WLAST_o(d3_sa_wlast), .sa_WVALID_o(d3_sa_wvalid), .sa_WREADY_i(d3_sa_wready),
    .ostd_cnt_o(d3_cnt), .wr_err_o(d3_err)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(aw_push && aw_full && !(wvalid && wready && wlast)))
        else $error("push while full without a same-cycle pop");
      assert (!(d3_push && d3_full && !(d3_wvalid && d3_wready && d3_wlast)))
        else $error("push while full without a same-cycle pop (dut3)");
    end
  end

  typedef struct {
    logic       push;
    logic [1:0] id;
    logic       wv, wl;
    logic [3:0] rdy;
    logic       e_full;
    logic [2:0] e_cnt;
    logic       e_wr;
    logic [3:0] e_sv;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic p, input logic [1:0] id, input logic wv, input logic wl,
                     input logic [3:0] rdy, input logic f, input logic [2:0] c,
                     input logic wr, input logic [3:0] sv);
    tbl.push_back('{p, id, wv, wl, rdy, f, c, wr, sv});
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #1;
    chk("rst_full", aw_full, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_wready", wready, 0);
    chk("rst_sv", sa_wvalid, 0);
    chk("rst_err", wr_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single 4-beat burst to slave 2 with one stall cycle
    add(0,0,0,0,4'hF, 0,0,0,4'h0);
    add(1,2,1,0,4'hF, 0,0,0,4'h0);
    add(0,0,1,0,4'hF, 0,1,1,4'h4);
    add(0,0,1,0,4'hB, 0,1,0,4'h4);
    add(0,0,1,0,4'hF, 0,1,1,4'h4);
    add(0,0,1,0,4'hF, 0,1,1,4'h4);
    add(0,0,1,1,4'hF, 0,1,1,4'h4);
    add(0,0,1,1,4'hF, 0,0,0,4'h0);
    // fill then back-to-back single-beat bursts
    add(1,0,0,0,4'hF, 0,0,0,4'h0);
    add(1,1,0,0,4'hF, 0,1,1,4'h0);
    add(1,3,0,0,4'hF, 0,2,1,4'h0);
    add(1,0,0,0,4'hF, 0,3,1,4'h0);
    add(0,0,0,0,4'hF, 1,4,1,4'h0);
    add(0,0,1,1,4'hF, 1,4,1,4'h1);
    add(0,0,1,1,4'hD, 0,3,0,4'h2);
    add(0,0,1,1,4'hF, 0,3,1,4'h2);
    add(0,0,1,1,4'hF, 0,2,1,4'h8);
    add(0,0,1,1,4'hF, 0,1,1,4'h1);
    add(0,0,0,0,4'hF, 0,0,0,4'h0);
    // pop while full with a simultaneous push of ID 1
    add(1,2,0,0,4'hF, 0,0,0,4'h0);
    add(1,1,0,0,4'hF, 0,1,1,4'h0);
    add(1,0,0,0,4'hF, 0,2,1,4'h0);
    add(1,3,0,0,4'hF, 0,3,1,4'h0);
    add(1,1,1,1,4'hF, 1,4,1,4'h4);
    add(0,0,0,0,4'hF, 1,4,1,4'h0);
    add(0,0,1,1,4'hF, 1,4,1,4'h2);
    add(0,0,1,1,4'hF, 0,3,1,4'h1);
    add(0,0,1,1,4'hF, 0,2,1,4'h8);
    add(0,0,1,1,4'hF, 0,1,1,4'h2);
    add(0,0,0,0,4'hF, 0,0,0,4'h0);
    // beat presented with its own AW waits one cycle
    add(1,1,1,1,4'hF, 0,0,0,4'h0);
    add(0,0,1,1,4'hF, 0,1,1,4'h2);
    add(0,0,0,0,4'hF, 0,0,0,4'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      aw_push = tbl[i].push; aw_id = tbl[i].id;
      wvalid = tbl[i].wv; wlast = tbl[i].wl; sa_wready = tbl[i].rdy;
      wdata = 32'hA500_0000 + 32'(i); wstrb = 4'(i);
      #1;
      chk($sformatf("v%0d_full", i), aw_full, tbl[i].e_full);
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d_wready", i), wready, tbl[i].e_wr);
      chk($sformatf("v%0d_sv", i), sa_wvalid, tbl[i].e_sv);
      chk($sformatf("v%0d_wdata", i), sa_wdata, {4{wdata}});
      chk($sformatf("v%0d_wstrb", i), sa_wstrb, {4{wstrb}});
      chk($sformatf("v%0d_wlast", i), sa_wlast, {4{wlast}});
    end
    chk("main_err", wr_err, 0);

    // reset mid-burst with three entries outstanding
    @(negedge clk); aw_push = 1; aw_id = 2; wvalid = 0; wlast = 0; sa_wready = 4'hF;
    @(negedge clk); aw_id = 0;
    @(negedge clk); aw_id = 1;
    @(negedge clk); aw_push = 0; wvalid = 1;
    #1;
    chk("mb_cnt", cnt, 3);
    chk("mb_sv", sa_wvalid, 4'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_cnt", cnt, 0);
    chk("ar_full", aw_full, 0);
    chk("ar_wready", wready, 0);
    chk("ar_sv", sa_wvalid, 0);
    chk("ar_err", wr_err, 0);
    @(negedge clk); rst_n = 1'b1; wvalid = 0; aw_push = 1; aw_id = 3;
    @(negedge clk); aw_push = 0; wvalid = 1; wlast = 1;
    #1;
    chk("pr_cnt", cnt, 1);
    chk("pr_sv", sa_wvalid, 4'h8);
    chk("pr_wready", wready, 1);
    @(negedge clk); wvalid = 0; wlast = 0;
    #1 chk("pr_cnt_after", cnt, 0);

    // out-of-range sink on the 3-slave instance
    @(negedge clk); d3_push = 1; d3_id = 3;
    @(negedge clk); d3_push = 0; d3_wvalid = 1; d3_wlast = 0; d3_sa_wready = 3'b000;
    #1;
    chk("oor_cnt", d3_cnt, 1);
    chk("oor_wready0", d3_wready, 1);
    chk("oor_sv0", d3_sa_wvalid, 0);
    chk("oor_err0", d3_err, 0);
    @(negedge clk); d3_wlast = 1;
    #1;
    chk("oor_wready1", d3_wready, 1);
    chk("oor_sv1", d3_sa_wvalid, 0);
    chk("oor_err1", d3_err, 0);
    @(negedge clk); d3_wvalid = 0; d3_wlast = 0;
    #1;
    chk("oor_err_pulse", d3_err, 1);
    chk("oor_cnt_after", d3_cnt, 0);
    @(negedge clk); d3_push = 1; d3_id = 2;
    #1 chk("oor_err_clear", d3_err, 0);
    @(negedge clk); d3_push = 0; d3_wvalid = 1; d3_wlast = 1; d3_sa_wready = 3'b100;
    #1;
    chk("d3_sv", d3_sa_wvalid, 3'b100);
    chk("d3_wready", d3_wready, 1);
    chk("d3_wdata", d3_wdata, {3{32'h0BAD_F00D}});
    @(negedge clk); d3_wvalid = 0; d3_wlast = 0;
    #1;
    chk("d3_cnt_after", d3_cnt, 0);
    chk("d3_no_err", d3_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
